// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: operand bypass selection, load-use and long-latency
// scoreboard interlocks, flush sequencing under cache misses, stall watchdog.
module pipe_hazard_unit #(
    parameter int NSTG    = 4,
    parameter int NSRC    = 2,
    parameter int RW      = 5,
    parameter int TIMEOUT = 255,
    localparam int SELW   = $clog2(NSTG + 1),
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC*RW-1:0]   src_addr,
    input  logic [NSRC-1:0]      src_used,
    input  logic [NSTG-1:0]      stg_wr,
    input  logic [NSTG*RW-1:0]   stg_rd,
    input  logic [NSTG-1:0]      stg_ready,
    input  logic                 ll_issue,
    input  logic [RW-1:0]        ll_rd,
    input  logic                 ll_done,
    input  logic [RW-1:0]        ll_done_rd,
    input  logic                 mem_busy,
    input  logic                 flush,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 pc_wr,
    output logic                 if_id_wr,
    output logic [NSTG-1:0]      stage_wr,
    output logic                 bubble,
    output logic [CW-1:0]        stall_cnt,
    output logic                 timeout
);

    localparam int NREG = 2 ** RW;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

    typedef enum logic {ST_RUN, ST_FLUSH_WAIT} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_next;
    logic [CW-1:0]   r_stall_cnt;
    logic            r_timeout;
    logic [NSRC-1:0] w_op_stall;
    logic            w_data_stall;
    logic            w_front_en;
    logic            w_back_en;
    logic            w_bubble;
    logic            w_ll_set;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic [RW-1:0]   w_addr;
            logic [SELW-1:0] w_sel;
            logic            w_rdy;

            assign w_addr = src_addr[gi*RW +: RW];

            // Scan farthest-to-nearest so the nearest matching stage wins.
            always_comb begin
                w_sel = '0;
                w_rdy = 1'b1;
                for (int k = NSTG - 1; k >= 0; k--) begin
                    if (stg_wr[k] && (stg_rd[k*RW +: RW] == w_addr)) begin
                        w_sel = SELW'(k + 1);
                        w_rdy = stg_ready[k];
                    end
                end
                if (!src_used[gi] || (w_addr == '0)) begin
                    w_sel = '0;
                    w_rdy = 1'b1;
                end
            end

            assign fwd_sel[gi*SELW +: SELW] = w_sel;
            assign w_op_stall[gi] = ((w_sel != '0) && !w_rdy) ||
                                    (src_used[gi] && r_pending[w_addr]);
        end
    endgenerate

    assign w_data_stall = (|w_op_stall) || (ll_issue && r_pending[ll_rd]);

    always_comb begin
        w_front_en   = 1'b1;
        w_back_en    = 1'b1;
        w_bubble     = 1'b0;
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (flush && !mem_busy) begin
                    w_bubble = 1'b1;
                end else if (flush) begin
                    w_front_en   = 1'b0;
                    w_back_en    = 1'b0;
                    w_state_next = ST_FLUSH_WAIT;
                end else if (mem_busy) begin
                    w_front_en = 1'b0;
                    w_back_en  = 1'b0;
                end else if (w_data_stall) begin
                    w_front_en = 1'b0;
                    w_bubble   = 1'b1;
                end
            end
            ST_FLUSH_WAIT: begin
                // Extra flush pulses here are absorbed; only mem_busy matters.
                if (mem_busy) begin
                    w_front_en = 1'b0;
                    w_back_en  = 1'b0;
                end else begin
                    w_bubble     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    assign pc_wr    = w_front_en;
    assign if_id_wr = w_front_en;
    assign stage_wr = {NSTG{w_back_en}};
    assign bubble   = w_bubble;

    assign w_ll_set = ll_issue && stage_wr[0] && !w_bubble;

    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    always_comb begin
        w_pending_next = r_pending;
        if (ll_done) begin
            w_pending_next[ll_done_rd] = 1'b0;
        end
        if (w_ll_set) begin
            w_pending_next[ll_rd] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_pending   <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            if (w_front_en) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CW'(1);
            end
            if (r_stall_cnt == TO_VAL) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign timeout   = r_timeout || (r_stall_cnt == TO_VAL);

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: vector table, directed corner sequences and
// randomized traffic against a behavioural model.
module tb_pipe_hazard_unit;

    localparam int NSTG = 4;
    localparam int NSRC = 2;
    localparam int RW   = 5;
    localparam int SELW = 3;
    localparam int CW   = 8;
    localparam int TMO  = 255;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NSRC*RW-1:0]   src_addr;
    logic [NSRC-1:0]      src_used;
    logic [NSTG-1:0]      stg_wr;
    logic [NSTG*RW-1:0]   stg_rd;
    logic [NSTG-1:0]      stg_ready;
    logic                 ll_issue;
    logic [RW-1:0]        ll_rd;
    logic                 ll_done;
    logic [RW-1:0]        ll_done_rd;
    logic                 mem_busy;
    logic                 flush;
    logic [NSRC*SELW-1:0] fwd_sel;
    logic                 pc_wr;
    logic                 if_id_wr;
    logic [NSTG-1:0]      stage_wr;
    logic                 bubble;
    logic [CW-1:0]        stall_cnt;
    logic                 timeout;
    logic [NSRC*SELW-1:0] wd_fwd_sel;
    logic                 wd_pc_wr;
    logic                 wd_if_id_wr;
    logic [NSTG-1:0]      wd_stage_wr;
    logic                 wd_bubble;
    logic [3:0]           wd_stall_cnt;
    logic                 wd_timeout;

    always #5 clk = ~clk;

    pipe_hazard_unit dut (
        .clk(clk), .rst(rst), .src_addr(src_addr), .src_used(src_used),
        .stg_wr(stg_wr), .stg_rd(stg_rd), .stg_ready(stg_ready),
        .ll_issue(ll_issue), .ll_rd(ll_rd), .ll_done(ll_done), .ll_done_rd(ll_done_rd),
        .mem_busy(mem_busy), .flush(flush), .fwd_sel(fwd_sel), .pc_wr(pc_wr),
        .if_id_wr(if_id_wr), .stage_wr(stage_wr), .bubble(bubble),
        .stall_cnt(stall_cnt), .timeout(timeout)
    );

    pipe_hazard_unit #(.TIMEOUT(8)) u_wd (
        .clk(clk), .rst(rst), .src_addr(src_addr), .src_used(src_used),
        .stg_wr(stg_wr), .stg_rd(stg_rd), .stg_ready(stg_ready),
        .ll_issue(ll_issue), .ll_rd(ll_rd), .ll_done(ll_done), .ll_done_rd(ll_done_rd),
        .mem_busy(mem_busy), .flush(flush), .fwd_sel(wd_fwd_sel), .pc_wr(wd_pc_wr),
        .if_id_wr(wd_if_id_wr), .stage_wr(wd_stage_wr), .bubble(wd_bubble),
        .stall_cnt(wd_stall_cnt), .timeout(wd_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit m_pend [32];
    bit m_fw;
    bit m_to;
    int m_cnt;
    int e_sel [2];
    bit e_pc;
    bit e_bub;
    bit e_nfw;
    bit e_to;
    int e_stg;

    typedef struct {
        logic [9:0]  sa;
        logic [1:0]  su;
        logic [3:0]  sw;
        logic [19:0] sr;
        logic [3:0]  sy;
        logic        mb;
        int          s0;
        int          s1;
        logic        pc;
        logic        bub;
        logic [3:0]  stg;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[r]) m_pend[r] = 1'b0;
        m_fw  = 1'b0;
        m_to  = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_eval();
        bit haz;
        bit found;
        int a;
        haz = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            a = int'(src_addr[i*RW +: RW]);
            e_sel[i] = 0;
            if (src_used[i] && a != 0) begin
                found = 1'b0;
                for (int k = 0; k < NSTG; k++) begin
                    if (!found && stg_wr[k] && int'(stg_rd[k*RW +: RW]) == a) begin
                        found = 1'b1;
                        e_sel[i] = k + 1;
                        if (!stg_ready[k]) haz = 1'b1;
                    end
                end
                if (m_pend[a]) haz = 1'b1;
            end
        end
        if (ll_issue && m_pend[int'(ll_rd)]) haz = 1'b1;
        e_pc  = 1'b1;
        e_stg = 15;
        e_bub = 1'b0;
        e_nfw = m_fw;
        if (m_fw) begin
            if (mem_busy) begin
                e_pc = 1'b0; e_stg = 0;
            end else begin
                e_bub = 1'b1; e_nfw = 1'b0;
            end
        end else if (flush && !mem_busy) begin
            e_bub = 1'b1;
        end else if (flush) begin
            e_pc = 1'b0; e_stg = 0; e_nfw = 1'b1;
        end else if (mem_busy) begin
            e_pc = 1'b0; e_stg = 0;
        end else if (haz) begin
            e_pc = 1'b0; e_bub = 1'b1;
        end
        e_to = m_to || (m_cnt == TMO);
    endtask

    task automatic model_check();
        check("fwd_sel0", int'(fwd_sel[2:0]), e_sel[0]);
        check("fwd_sel1", int'(fwd_sel[5:3]), e_sel[1]);
        check("pc_wr", int'(pc_wr), int'(e_pc));
        check("if_id_wr", int'(if_id_wr), int'(e_pc));
        check("stage_wr", int'(stage_wr), e_stg);
        check("bubble", int'(bubble), int'(e_bub));
        check("stall_cnt", int'(stall_cnt), m_cnt);
        check("timeout", int'(timeout), int'(e_to));
    endtask

    task automatic model_commit();
        if (ll_done) m_pend[int'(ll_done_rd)] = 1'b0;
        if (ll_issue && e_stg != 0 && !e_bub && ll_rd != 0) m_pend[int'(ll_rd)] = 1'b1;
        m_fw  = e_nfw;
        m_cnt = e_pc ? 0 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        m_to  = e_to;
    endtask

    task automatic settle();
        #2;
        model_eval();
        model_check();
    endtask

    task automatic clock();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic tick();
        settle();
        clock();
    endtask

    task automatic idle();
        src_addr = '0; src_used = '0; stg_wr = '0; stg_rd = '0; stg_ready = '1;
        ll_issue = 1'b0; ll_rd = '0; ll_done = 1'b0; ll_done_rd = '0;
        mem_busy = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        settle();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        tbl[0] = '{{5'd0, 5'd7}, 2'b01, 4'b0110, {5'd0, 5'd7, 5'd7, 5'd0}, 4'hF, 1'b0, 2, 0, 1'b1, 1'b0, 4'hF};
        tbl[1] = '{{5'd0, 5'd0}, 2'b11, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, 4'h0, 1'b0, 0, 0, 1'b1, 1'b0, 4'hF};
        tbl[2] = '{{5'd4, 5'd5}, 2'b11, 4'b1111, {5'd1, 5'd2, 5'd3, 5'd6}, 4'hF, 1'b0, 0, 0, 1'b1, 1'b0, 4'hF};
        tbl[3] = '{{5'd0, 5'd12}, 2'b01, 4'b1000, {5'd12, 5'd0, 5'd0, 5'd0}, 4'b1000, 1'b0, 4, 0, 1'b1, 1'b0, 4'hF};
        tbl[4] = '{{5'd0, 5'd6}, 2'b01, 4'b0101, {5'd0, 5'd6, 5'd0, 5'd6}, 4'b0100, 1'b0, 1, 0, 1'b0, 1'b1, 4'hF};
        tbl[5] = '{{5'd6, 5'd0}, 2'b01, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd6}, 4'h0, 1'b0, 0, 0, 1'b1, 1'b0, 4'hF};
        tbl[6] = '{{5'd10, 5'd11}, 2'b11, 4'b0011, {5'd0, 5'd0, 5'd10, 5'd11}, 4'hF, 1'b0, 1, 2, 1'b1, 1'b0, 4'hF};
        tbl[7] = '{{5'd0, 5'd6}, 2'b01, 4'b0101, {5'd0, 5'd6, 5'd0, 5'd6}, 4'b0100, 1'b1, 1, 0, 1'b0, 1'b0, 4'h0};
        tbl[8] = '{{5'd0, 5'd7}, 2'b01, 4'b0000, {5'd7, 5'd7, 5'd7, 5'd7}, 4'h0, 1'b0, 0, 0, 1'b1, 1'b0, 4'hF};

        idle();
        #1;
        do_reset();
        check("rst_timeout_wd", int'(wd_timeout), 0);

        // Combinational vectors
        for (int v = 0; v < 9; v++) begin
            idle();
            src_addr = tbl[v].sa; src_used = tbl[v].su; stg_wr = tbl[v].sw;
            stg_rd = tbl[v].sr; stg_ready = tbl[v].sy; mem_busy = tbl[v].mb;
            settle();
            check("tbl_sel0", int'(fwd_sel[2:0]), tbl[v].s0);
            check("tbl_sel1", int'(fwd_sel[5:3]), tbl[v].s1);
            check("tbl_pc_wr", int'(pc_wr), int'(tbl[v].pc));
            check("tbl_bubble", int'(bubble), int'(tbl[v].bub));
            check("tbl_stage_wr", int'(stage_wr), int'(tbl[v].stg));
            clock();
        end

        // Load-use then release
        idle();
        src_addr = {5'd3, 5'd0}; src_used = 2'b10; stg_wr = 4'b0001;
        stg_rd = {5'd0, 5'd0, 5'd0, 5'd3}; stg_ready = 4'b1110;
        settle();
        check("lu_pc_wr", int'(pc_wr), 0);
        check("lu_bubble", int'(bubble), 1);
        check("lu_stage_wr", int'(stage_wr), 15);
        clock();
        stg_ready = 4'hF;
        settle();
        check("lu_rel_sel1", int'(fwd_sel[5:3]), 1);
        check("lu_rel_pc_wr", int'(pc_wr), 1);
        clock();

        // Scoreboard
        idle(); ll_issue = 1'b1; ll_rd = 5'd9;
        settle();
        check("sb_issue_bubble", int'(bubble), 0);
        clock();
        idle(); src_addr = {5'd0, 5'd9}; src_used = 2'b01;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("sb_wait_pc_wr", int'(pc_wr), 0);
            clock();
        end
        ll_done = 1'b1; ll_done_rd = 5'd9;
        settle();
        check("sb_done_cycle_pc_wr", int'(pc_wr), 0);
        clock();
        ll_done = 1'b0;
        settle();
        check("sb_release_pc_wr", int'(pc_wr), 1);
        clock();
        idle(); ll_issue = 1'b1; ll_rd = 5'd9; ll_done = 1'b1; ll_done_rd = 5'd9;
        tick();
        idle(); src_addr = {5'd0, 5'd9}; src_used = 2'b01;
        settle();
        check("sb_set_wins_pc_wr", int'(pc_wr), 0);
        clock();
        ll_done = 1'b1; ll_done_rd = 5'd9;
        tick();
        ll_done = 1'b0;
        settle();
        check("sb_clear_pc_wr", int'(pc_wr), 1);
        clock();

        // Flush under miss, with a second flush pulse absorbed
        idle(); flush = 1'b1; mem_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            flush = (c != 2);
            settle();
            check("fl_wait_pc_wr", int'(pc_wr), 0);
            check("fl_wait_stage_wr", int'(stage_wr), 0);
            clock();
        end
        idle();
        settle();
        check("fl_apply_pc_wr", int'(pc_wr), 1);
        check("fl_apply_stage_wr", int'(stage_wr), 15);
        check("fl_apply_bubble", int'(bubble), 1);
        clock();
        settle();
        check("fl_run_bubble", int'(bubble), 0);
        clock();

        // Reset in FLUSH_WAIT drops the pending flush
        flush = 1'b1; mem_busy = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        idle();
        do_reset();
        settle();
        check("fl_rst_bubble", int'(bubble), 0);
        check("fl_rst_pc_wr", int'(pc_wr), 1);
        clock();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NSRC; i++) src_addr[i*RW +: RW] = RW'($urandom_range(0, 7));
            src_used  = NSRC'($urandom);
            stg_wr    = NSTG'($urandom);
            for (int k = 0; k < NSTG; k++) stg_rd[k*RW +: RW] = RW'($urandom_range(0, 7));
            stg_ready = NSTG'($urandom);
            ll_issue  = ($urandom_range(0, 99) < 15);
            ll_rd     = RW'($urandom_range(0, 15));
            ll_done   = ($urandom_range(0, 99) < 35);
            ll_done_rd = RW'($urandom_range(0, 15));
            mem_busy  = ($urandom_range(0, 99) < 20);
            flush     = ($urandom_range(0, 99) < 5);
            tick();
        end

        // Watchdog on the TIMEOUT=8 instance
        idle();
        do_reset();
        for (int j = 0; j < 10; j++) begin
            mem_busy = 1'b1;
            settle();
            check("wd_cnt", int'(wd_stall_cnt), j);
            check("wd_timeout", int'(wd_timeout), (j >= 8) ? 1 : 0);
            clock();
        end
        mem_busy = 1'b0;
        settle();
        check("wd_drop_cnt", int'(wd_stall_cnt), 10);
        check("wd_drop_pc_wr", int'(wd_pc_wr), 1);
        check("wd_drop_timeout", int'(wd_timeout), 1);
        clock();
        settle();
        check("wd_idle_cnt", int'(wd_stall_cnt), 0);
        check("wd_idle_timeout", int'(wd_timeout), 1);
        check("wd_idle_bubble", int'(wd_bubble), 0);
        check("wd_idle_if_id_wr", int'(wd_if_id_wr), 1);
        check("wd_idle_stage_wr", int'(wd_stage_wr), 15);
        check("wd_idle_sel", int'(wd_fwd_sel), 0);
        clock();
        mem_busy = 1'b1;
        for (int j = 0; j < 17; j++) tick();
        settle();
        check("wd_saturate_cnt", int'(wd_stall_cnt), 15);
        clock();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
